// File: rtl/jtframe_pocket_upload.sv
// Pocket dataslot upload bridge: fetches one 32-bit word per rd_req as four
// byte reads from core memory and returns the packed word on rd_data.
// Handshake: rd_req is accepted only while uploading=1 and busy=0; each
// accepted request yields exactly one rd_valid pulse unless rst intervenes.
// A request that arrives when it cannot be accepted is dropped and sets err.
module jtframe_pocket_upload #(
    parameter int AW     = 25,
    parameter int RD_LAT = 2
) (
    input  logic          clk_rom,
    input  logic          rst,
    input  logic          i_upload_start,
    input  logic          i_upload_done,
    input  logic          i_rd_req,
    input  logic [31:0]   i_rd_addr,
    output logic [31:0]   o_rd_data,
    output logic          o_rd_valid,
    output logic          o_busy,
    output logic          o_uploading,
    output logic          o_err,
    output logic [AW-1:0] o_ioctl_addr,
    output logic          o_ioctl_rd,
    input  logic [7:0]    i_ioctl_din,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PACK} state_t;

    // Last WAIT count value; ioctl_din is valid in that cycle.
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [2:0]    r_lat;
    logic [AW-3:0] r_addr;
    logic [23:0]   r_buf;
    logic [31:0]   r_rd_data;
    logic          r_rd_valid;
    logic          r_busy;
    logic          r_uploading;
    logic          r_err;
    logic [AW-1:0] r_ioctl_addr;
    logic          r_ioctl_rd;

    logic          w_accept;
    logic          w_drop;
    logic          w_unused_addr;

    assign w_accept      = i_rd_req & r_uploading & ~r_busy;
    assign w_drop        = i_rd_req & ~w_accept;
    // Word addresses above the core address space are ignored.
    assign w_unused_addr = ^i_rd_addr[31:AW-2];

    assign o_rd_data    = r_rd_data;
    assign o_rd_valid   = r_rd_valid;
    assign o_busy       = r_busy;
    assign o_uploading  = r_uploading;
    assign o_err        = r_err;
    assign o_ioctl_addr = r_ioctl_addr;
    assign o_ioctl_rd   = r_ioctl_rd;
    assign o_dbg_state  = r_state;

    // Session window and sticky drop flag; start beats done when coincident.
    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            r_uploading <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (i_upload_start)     r_uploading <= 1'b1;
            else if (i_upload_done) r_uploading <= 1'b0;

            if (i_upload_start)     r_err <= 1'b0;
            else if (w_drop)        r_err <= 1'b1;
        end
    end

    // Word fetch FSM: ISSUE strobes one byte read, WAIT covers the read
    // latency and captures the byte, PACK presents the assembled word.
    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_lat        <= 3'd0;
            r_addr       <= '0;
            r_buf        <= 24'd0;
            r_rd_data    <= 32'd0;
            r_rd_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_ioctl_addr <= '0;
            r_ioctl_rd   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr       <= i_rd_addr[AW-3:0];
                        r_idx        <= 2'd0;
                        r_ioctl_addr <= {i_rd_addr[AW-3:0], 2'b00};
                        r_ioctl_rd   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_ioctl_rd <= 1'b0;
                    r_lat      <= 3'd0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_lat <= 3'd0;
                        if (r_idx == 2'd3) begin
                            // Last lane goes straight into the output word.
                            r_rd_data  <= {i_ioctl_din, r_buf};
                            r_rd_valid <= 1'b1;
                            r_state    <= PACK;
                        end else begin
                            case (r_idx)
                                2'd0:    r_buf[7:0]   <= i_ioctl_din;
                                2'd1:    r_buf[15:8]  <= i_ioctl_din;
                                default: r_buf[23:16] <= i_ioctl_din;
                            endcase
                            r_idx        <= r_idx + 2'd1;
                            r_ioctl_addr <= {r_addr, r_idx + 2'd1};
                            r_ioctl_rd   <= 1'b1;
                            r_state      <= ISSUE;
                        end
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                PACK: begin
                    r_rd_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
